hex_display_scanner: RTL and testbench
======================================

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed 7-segment digits (legal range 2..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 50000, giving the number of clk cycles each digit stays lit (legal range 2..2^20).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port load  input  1  when high, value and digit_en are captured into shadow registers.
REQ-006 The block SHALL have port value  input  4*NUM_DIGITS  hex number to display; nibble i drives digit i, with digit 0 the least significant.
REQ-007 The block SHALL have port digit_en  input  NUM_DIGITS  per-digit enable mask; a 0 bit blanks that digit.
REQ-008 The block SHALL have port lz_suppress  input  1  leading-zero suppression enable; sampled live, not shadowed.
REQ-009 The block SHALL have port hex_digit  output  4  nibble of the currently lit digit, fed to the hex-to-7-segment converter.
REQ-010 The block SHALL have port anode  output  NUM_DIGITS  digit select, active-low, one-hot-low.
REQ-011 The block SHALL have port blank  output  1  high when the current digit is dark.
REQ-012 The block SHALL have port digit_idx  output  3  index of the currently lit digit.
REQ-013 The block SHALL have port scan_tick  output  1  one-cycle pulse on every digit advance.

Function
REQ-014 The block SHALL capture value and digit_en into the shadow registers on each rising edge where load=1 and reset=0; otherwise the shadows SHALL hold.
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the terminal count (REFRESH_DIV-1) is the advance event.
REQ-016 On the advance event, the scan index SHALL increment, wrapping from NUM_DIGITS-1 to 0.
REQ-017 All outputs SHALL be registered, and each SHALL be computed from the scan index, shadows and lz_suppress as they stood before the same edge, giving one cycle of latency from any state change to the outputs.
REQ-018 A digit i SHALL be considered suppressed when lz_suppress=1, i!=0, and shadow nibbles i..NUM_DIGITS-1 are all zero; digit 0 is never suppressed.
REQ-019 For current index k, the block SHALL drive hex_digit = shadow nibble k and digit_idx = k.
REQ-020 If digit k is enabled and not suppressed, the block SHALL drive anode bit k = 0, all other anode bits = 1, and blank = 0.
REQ-021 If digit k is disabled or suppressed, the block SHALL drive all anode bits = 1 and blank = 1, with hex_digit still equal to the nibble.
REQ-022 The block SHALL drive scan_tick = 1 for exactly the one cycle following each advance event.
REQ-023 A load coincident with an advance event SHALL have both take effect on that edge, and the next output SHALL show the new nibble at the new index.
REQ-024 A load SHALL NOT reset the prescaler or the scan index, so the scan rate is independent of load activity.
REQ-025 At most one anode bit SHALL be low at any cycle.

Reset
REQ-026 When reset=1 at a rising edge, the block SHALL clear the prescaler to 0, the scan index to 0, the value shadow to 0, and the digit_en shadow to all ones.
REQ-027 When reset=1 at a rising edge, the outputs SHALL become hex_digit=0, anode=all ones, blank=1, digit_idx=0 and scan_tick=0.
REQ-028 When reset and load are both high, reset SHALL win.
REQ-029 A reset asserted mid-scan SHALL abort the scan, with no tick pending.
REQ-030 The first advance after reset release SHALL occur REFRESH_DIV cycles after the release edge.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-031 Reset then load value=16'h1A2F, digit_en=4'hF, lz_suppress=0: the bench SHALL observe hex_digit sequence F,2,A,1 repeating, anode 1110,1101,1011,0111, each held 4 cycles, scan_tick every 4th cycle.
REQ-032 Load value=16'h0042, lz_suppress=1: the bench SHALL observe digits 0,1 lit (2,4) and digits 2,3 with anode=1111 and blank=1; with lz_suppress=0, digits 2,3 show 0 and are lit.
REQ-033 Load value=16'h0000, lz_suppress=1: the bench SHALL observe only digit 0 lit, showing 0.
REQ-034 Load digit_en=4'b0101: the bench SHALL observe anode=1111 and blank=1 during indices 1 and 3, with the scan timing unchanged.
REQ-035 Load 16'h1234 pulsed on the same edge as an advance from index 0 to 1: the next output SHALL show hex_digit=3 with anode=1101.
REQ-036 Assert reset at index 2 mid-count: the next cycle SHALL show anode=1111, digit_idx=0 and blank=1, and after release a load of 16'h1234 SHALL restart from digit 0 (value 4), with the first advance 4 cycles after release.

Source files
------------

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - multiplexed hex 7-segment scanner
// Shadowed value/enable, prescaled digit scan, leading-zero blanking, registered outputs.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  output logic [3:0]              hex_digit,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    blank,
  output logic [2:0]              digit_idx,
  output logic                    scan_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   val_q, val_d;
  logic [NUM_DIGITS-1:0]     en_q, en_d;
  logic [3:0]                hex_q, hex_d;
  logic [NUM_DIGITS-1:0]     anode_q, anode_d;
  logic                      blank_q, blank_d;
  logic [2:0]                didx_q;
  logic                      tick_q;
  logic                      advance;
  logic                      zero_above;
  logic                      lit;
  logic [NUM_DIGITS-1:0]     supp;

  always_comb begin
    advance = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d   = advance ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    if (advance) begin
      idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
    val_d = load ? value : val_q;
    en_d  = load ? digit_en : en_q;

    // A digit is suppressed when it and every more-significant nibble are zero.
    zero_above = 1'b1;
    supp       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (val_q[4*i +: 4] == 4'h0);
      supp[i]    = lz_suppress & zero_above & (i != 0);
    end

    hex_d = 4'h0;
    lit   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        hex_d = val_q[4*i +: 4];
        lit   = en_q[i] & ~supp[i];
      end
    end

    anode_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_d[i] = ~(lit & (idx_q == 3'(i)));
    end
    blank_d = ~lit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      val_q   <= '0;
      en_q    <= '1;
      hex_q   <= 4'h0;
      anode_q <= '1;
      blank_q <= 1'b1;
      didx_q  <= 3'd0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      en_q    <= en_d;
      hex_q   <= hex_d;
      anode_q <= anode_d;
      blank_q <= blank_d;
      didx_q  <= idx_q;
      tick_q  <= advance;
    end
  end

  assign hex_digit = hex_q;
  assign anode     = anode_q;
  assign blank     = blank_q;
  assign digit_idx = didx_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - self-checking bench for hex_display_scanner
// Reference model derives scan position from the edge count since reset.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_suppress = 1'b0;
  logic [3:0]  hex_digit;
  logic [3:0]  anode;
  logic        blank;
  logic [2:0]  digit_idx;
  logic        scan_tick;

  int total = 0;
  int bad = 0;

  int          m_n = 0;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_en = 4'hF;

  hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .digit_en(digit_en),
    .lz_suppress(lz_suppress), .hex_digit(hex_digit), .anode(anode), .blank(blank),
    .digit_idx(digit_idx), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h at n=%0d", tag, got, exp, m_n);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic [15:0] v,
                      input logic [3:0] en, input logic lz);
    int          idx;
    logic [15:0] sh;
    logic        lit;
    logic [3:0]  e_hex, e_an;
    logic        e_blank, e_tick;
    if (rst) begin
      idx = 0; e_hex = 4'h0; e_an = 4'hF; e_blank = 1'b1; e_tick = 1'b0;
    end else begin
      idx     = (m_n / 4) % 4;
      sh      = m_val >> (4 * idx);
      e_hex   = sh[3:0];
      lit     = m_en[idx] && !(lz && idx != 0 && sh == 16'h0);
      e_an    = lit ? ~(4'b0001 << idx) : 4'hF;
      e_blank = !lit;
      e_tick  = (m_n % 4 == 3);
    end
    reset = rst; load = ld; value = v; digit_en = en; lz_suppress = lz;
    @(posedge clk);
    #1;
    chk("hex_digit", 16'(hex_digit), 16'(e_hex));
    chk("anode", 16'(anode), 16'(e_an));
    chk("blank", 16'(blank), 16'(e_blank));
    chk("digit_idx", 16'(digit_idx), 16'(idx));
    chk("scan_tick", 16'(scan_tick), 16'(e_tick));
    chk("anode_onehot", 16'($countones(~anode) <= 1), 16'd1);
    if (rst) begin
      m_n = 0; m_val = 16'h0; m_en = 4'hF;
    end else begin
      if (ld) begin
        m_val = v; m_en = en;
      end
      m_n++;
    end
  endtask

  initial begin
    logic [15:0] rv;
    int          r;
    // Reset, with a coincident load that must lose.
    step(1'b1, 1'b0, 16'h0, 4'hF, 1'b0);
    step(1'b1, 1'b1, 16'hBEEF, 4'h3, 1'b0);
    // Free running scan of 1A2F, first load lands with the release edge.
    step(1'b0, 1'b1, 16'h1A2F, 4'hF, 1'b0);
    repeat (34) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    // Leading-zero suppression on and off.
    step(1'b0, 1'b1, 16'h0042, 4'hF, 1'b1);
    repeat (17) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    repeat (17) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0000, 4'hF, 1'b1);
    repeat (17) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    // Enable mask 0101.
    step(1'b0, 1'b1, 16'h9876, 4'b0101, 1'b0);
    repeat (17) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    // Load coincident with the advance from index 0 to 1.
    while (m_n % 16 != 3) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 4'hF, 1'b0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("coincident_hex", 16'(hex_digit), 16'h3);
    chk("coincident_anode", 16'(anode), 16'(4'b1101));
    repeat (6) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    // Reset mid-count at index 2, then restart.
    while (m_n % 16 != 9) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'hF, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 4'hF, 1'b0);
    repeat (20) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(r < 3, r >= 3 && r < 20, rv, 4'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
